rf_access_arbiter: RTL
======================

Name: rf_access_arbiter

Overview:
- Shares the single read port and single write port of the 8x16 register file between two requesters (e.g. the instruction sequencer and the debug/load path).
- Accepts read, write and register-to-register copy requests, with round-robin arbitration and a valid/ready handshake.
- Returns a one-cycle response pulse to the owner of each request.
- Sits directly in front of the register file and drives its writenum/readnum/write/data_in; it is the only master of that file.

Parameters:
- DW, 16, data width (matches register file).
- AW, 3, register address width (8 registers).

Ports:
- clk  in  1  rising-edge clock, shared with the register file.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  2  bit i = requester i has a request.
- req_op  in  4  [2i+1:2i] = op of requester i: 00 read, 01 write, 10 copy, 11 reserved.
- req_ra  in  6  [3i+2:3i] = source register of requester i (read, copy).
- req_wa  in  6  [3i+2:3i] = destination register of requester i (write, copy).
- req_wdata  in  32  [16i+15:16i] = write data of requester i.
- req_ready  out  2  bit i = request of requester i accepted this cycle (combinational, at most one bit set).
- rsp_valid  out  2  one-hot, one-cycle response pulse to the request owner.
- rsp_rdata  out  16  response data, valid while rsp_valid != 0.
- rf_readnum  out  3  register file read address.
- rf_writenum  out  3  register file write address.
- rf_write  out  1  register file write enable.
- rf_data_in  out  16  register file write data.
- rf_data_out  in  16  register file combinational read data.

Behaviour:
- Reset:
  - rst_n sampled low at a rising edge gives: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_rdata=0, hold=0, owner=0, wa_q=0.
  - While rst_n is low, req_ready=0 and rf_write=0 combinationally.
- FSM states:
  - IDLE: accept requests.
  - COPY_WR: second cycle of a copy.
- Arbitration (IDLE only):
  - Exactly one valid requester: that requester is granted.
  - Both valid: requester rr_ptr is granted.
  - On every grant: req_ready[g]=1 and rr_ptr <= ~g.
  - In COPY_WR, req_ready=2'b00.
  - Requesters hold valid/op/addr/data stable until ready.
- Idle rf outputs: with no grant, rf_write=0, rf_readnum=0, rf_writenum=0, rf_data_in=0.
- READ (op 00), granted g:
  - rf_readnum = ra[g] in the grant cycle.
  - Next edge: rsp_rdata <= rf_data_out, rsp_valid <= 1<<g.
  - Latency 1; state stays IDLE.
- WRITE (op 01), granted g:
  - rf_write=1, rf_writenum=wa[g], rf_data_in=wdata[g] in the grant cycle.
  - Next edge: rsp_valid <= 1<<g, rsp_rdata <= wdata[g] (ack echo).
- COPY (op 10), granted g:
  - Grant cycle: rf_readnum=ra[g]; hold <= rf_data_out, wa_q <= wa[g], owner <= g; state -> COPY_WR. rsp_valid=0.
  - COPY_WR cycle: rf_write=1, rf_writenum=wa_q, rf_data_in=hold.
  - Next edge: rsp_valid <= 1<<owner, rsp_rdata <= hold; state -> IDLE.
  - ra == wa is legal; it rewrites the same value.
- Reserved (op 11): accepted, no rf access; next edge rsp_valid <= 1<<g, rsp_rdata <= 0.
- rsp_valid is 0 in every cycle not immediately following a completing operation. rsp_rdata holds its last value otherwise.
- Throughput:
  - READ/WRITE/reserved: one accept per cycle, back-to-back.
  - COPY: occupies 2 cycles; the next grant is possible in the cycle after COPY_WR.
- Ordering: writes commit at the grant edge, so a read granted the following cycle (either requester) returns the new value.
- Reset mid-copy: rst_n low during COPY_WR suppresses the write and returns to IDLE with no response.

Test Plan:
- Reset, then req 0 WRITE wa=3 wdata=16'hBEEF -> ready=01 same cycle, rf_write=1/writenum=3; next cycle rsp_valid=01, rsp_rdata=BEEF.
- After above, req 1 READ ra=3 -> ready=10; next cycle rsp_valid=10, rsp_rdata=BEEF.
- Both valid READs held 4 cycles from reset -> grants alternate 0,1,0,1 (ready 01,10,01,10), one rsp per cycle to the matching owner.
- Req 0 COPY ra=3 wa=5, req 1 READ ra=5 valid concurrently:
  - cycle 0: ready=01.
  - cycle 1: ready=00, rf_write=1, writenum=5, data_in=BEEF.
  - cycle 2: rsp_valid=01 with BEEF; ready=10.
  - cycle 3: rsp_valid=10 with BEEF.
- Start COPY ra=3 wa=6, drive rst_n=0 during COPY_WR -> rf_write=0 that cycle, no rsp_valid; later READ ra=6 returns 0 (register 6 unchanged).
- Req 1 op 11 -> ready=10, no rf_write; next cycle rsp_valid=10, rsp_rdata=0.

Source files
------------

// File: rtl/rf_access_arbiter.sv
// Purpose: arbitrates two requesters onto the single read/write port pair of the 8x16 register file.
// Latency: read/write/reserved respond 1 cycle after grant; copy responds 2 cycles after grant.
// Backpressure: req_ready is a combinational grant; nothing is granted while a copy is in its write cycle.
module rf_access_arbiter #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    input  logic [3:0]        req_op,
    input  logic [2*AW-1:0]   req_ra,
    input  logic [2*AW-1:0]   req_wa,
    input  logic [2*DW-1:0]   req_wdata,
    output logic [1:0]        req_ready,
    output logic [1:0]        rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic [AW-1:0]     rf_readnum,
    output logic [AW-1:0]     rf_writenum,
    output logic              rf_write,
    output logic [DW-1:0]     rf_data_in,
    input  logic [DW-1:0]     rf_data_out
);

    typedef enum logic {
        IDLE    = 1'b0,
        COPY_WR = 1'b1
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;

    state_t          state;
    state_t          state_nxt;
    logic            rr_ptr;
    logic            owner;
    logic [AW-1:0]   wa_q;
    logic [DW-1:0]   hold;

    logic            gnt_any;
    logic            gnt;
    logic [1:0]      g_op;
    logic [AW-1:0]   g_ra;
    logic [AW-1:0]   g_wa;
    logic [DW-1:0]   g_wdata;
    logic [1:0]      g_onehot;

    // Fields of the granted requester (also of requester 0 when nothing is granted).
    assign g_op     = gnt ? req_op[3:2]          : req_op[1:0];
    assign g_ra     = gnt ? req_ra[2*AW-1:AW]    : req_ra[AW-1:0];
    assign g_wa     = gnt ? req_wa[2*AW-1:AW]    : req_wa[AW-1:0];
    assign g_wdata  = gnt ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
    assign g_onehot = gnt ? 2'b10 : 2'b01;

    // Round-robin grant; only in IDLE and never while reset is asserted.
    always_comb begin
        gnt_any = 1'b0;
        gnt     = 1'b0;
        if (rst_n && state == IDLE) begin
            case (req_valid)
                2'b01:   begin gnt_any = 1'b1; gnt = 1'b0;   end
                2'b10:   begin gnt_any = 1'b1; gnt = 1'b1;   end
                2'b11:   begin gnt_any = 1'b1; gnt = rr_ptr; end
                default: begin gnt_any = 1'b0; gnt = 1'b0;   end
            endcase
        end
    end

    // Next state plus the combinational handshake and register-file drive.
    always_comb begin
        state_nxt   = state;
        req_ready   = 2'b00;
        rf_readnum  = '0;
        rf_writenum = '0;
        rf_write    = 1'b0;
        rf_data_in  = '0;
        case (state)
            IDLE: begin
                if (gnt_any) begin
                    req_ready = g_onehot;
                    case (g_op)
                        OP_READ: rf_readnum = g_ra;
                        OP_WRITE: begin
                            rf_write    = 1'b1;
                            rf_writenum = g_wa;
                            rf_data_in  = g_wdata;
                        end
                        OP_COPY: begin
                            rf_readnum = g_ra;
                            state_nxt  = COPY_WR;
                        end
                        default: ;
                    endcase
                end
            end
            COPY_WR: begin
                // Reset arriving mid-copy must not corrupt the destination register.
                rf_write    = rst_n;
                rf_writenum = wa_q;
                rf_data_in  = hold;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, arbitration pointer, copy capture registers and the response pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            rsp_valid <= 2'b00;
            rsp_rdata <= '0;
            hold      <= '0;
            owner     <= 1'b0;
            wa_q      <= '0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= 2'b00;
            if (state == IDLE && gnt_any) begin
                rr_ptr <= ~gnt;
                case (g_op)
                    OP_READ: begin
                        rsp_valid <= g_onehot;
                        rsp_rdata <= rf_data_out;
                    end
                    OP_WRITE: begin
                        rsp_valid <= g_onehot;
                        rsp_rdata <= g_wdata;
                    end
                    OP_COPY: begin
                        hold  <= rf_data_out;
                        wa_q  <= g_wa;
                        owner <= gnt;
                    end
                    default: begin
                        rsp_valid <= g_onehot;
                        rsp_rdata <= '0;
                    end
                endcase
            end else if (state == COPY_WR) begin
                rsp_valid <= owner ? 2'b10 : 2'b01;
                rsp_rdata <= hold;
            end
        end
    end

endmodule
